hex_msg_scroller: RTL and testbench
===================================

// Module: hex_msg_scroller
// PURPOSE
//   Producer side of the char_7seg display path. Buffers a stream of 4-bit character codes and
//   scrolls them right-to-left across NUM_DIGITS display positions at a fixed tick rate.
//   Drives one 4-bit code per digit; each code feeds one char_7seg decoder, and each decoder
//   drives one HEX display. Game logic pushes a message, such as a score or a bust/win
//   string, and pulses start.
// PARAMETERS
//   NUM_DIGITS  6           number of display positions (HEX0..HEX5)
//   FIFO_DEPTH  8           character buffer depth, power of 2, >= 2
//   TICK_DIV    25_000_000  clk cycles per scroll step (0.5 s at 50 MHz)
//   BLANK_CHAR  4'hF        code shifted into vacated positions and loaded at reset/clear
// PORTS
//   clk        in   1               system clock, rising edge
//   resetn     in   1               asynchronous reset, active-low
//   in_char    in   4               character code to enqueue
//   in_valid   in   1               in_char is valid this cycle
//   in_ready   out  1               buffer can accept a character (= !full)
//   start      in   1               one-cycle pulse: begin scrolling the buffered message
//   clear      in   1               synchronous flush of buffer and display
//   busy       out  1               high while in SCROLL or DRAIN
//   disp_chars out  4*NUM_DIGITS    digit k = disp_chars[4k+3:4k]; k=0 is the rightmost digit (HEX0)
// BEHAVIOUR
//   Reset (resetn=0, async): every digit = BLANK_CHAR, buffer empty, busy=0, state IDLE,
//     tick counter 0. in_ready=1 once out of reset.
//   Enqueue: a character is accepted on a rising edge where in_valid && in_ready. Enqueue is
//     allowed in every state. in_ready is derived from the registered count only, so at full it
//     stays 0 even if a pop occurs in the same cycle.
//   Tick: the counter runs only in SCROLL/DRAIN. It is cleared on entry to SCROLL. A step occurs
//     when the counter reaches TICK_DIV-1, and the counter then wraps to 0. The first step
//     happens TICK_DIV cycles after start is sampled.
//   Step: digit k <= digit k-1 for k = NUM_DIGITS-1..1. Digit 0 <= buffer head (popped) if
//     count != 0 at that edge, else BLANK_CHAR. A character enqueued on the step edge is not
//     visible until the next step.
//   FSM:
//     IDLE -> SCROLL  on start && count != 0. start with an empty buffer is ignored.
//     SCROLL: each step pops one character. A step that finds count == 0 shifts in a blank and
//       enters DRAIN with drain_cnt = 1.
//     DRAIN: each step shifts in a blank and increments drain_cnt.
//     DRAIN -> IDLE after the step where drain_cnt reaches NUM_DIGITS; the display is then all
//       blank.
//     DRAIN -> SCROLL if a step finds count != 0. That character is popped on the same step,
//       and drain_cnt is cleared.
//     start while busy is ignored.
//   clear: has priority over enqueue, step and start in the same cycle. It empties the buffer,
//     blanks all digits, and forces IDLE with the tick counter at 0. An in_valid in the clear
//     cycle is dropped.
//   The display holds its value in IDLE. Outputs are registered with no combinational input
//     to output path, except in_ready, which comes from the count register.
//   Widths: tick counter $clog2(TICK_DIV); count $clog2(FIFO_DEPTH)+1; pointers wrap modulo
//     FIFO_DEPTH.
// STRUCTURE
//   hex_disp_pkg: CHAR_W=4, BLANK code default, FSM state encoding (IDLE/SCROLL/DRAIN).
//   Sub-module char_fifo: sync FIFO, width CHAR_W, depth FIFO_DEPTH.
//     Ports: push, pop, din, dout, count, full, empty, flush.
//     Show-ahead: dout is valid whenever !empty.
//   Top level: FSM, tick divider, drain counter, NUM_DIGITS-entry shift register.
// TESTING (TICK_DIV=4, NUM_DIGITS=6, FIFO_DEPTH=8)
//   1. Reset: assert resetn=0 mid-scroll -> disp_chars=24'hFFFFFF, busy=0, in_ready=1 within the
//      same cycle (async).
//   2. Push 1,2,3, then start -> digit0=1 at cycle 4, then 2,1 at cycle 8, then 3,2,1 at
//      cycle 12. After three more steps busy persists through DRAIN. After 6 blank steps
//      (cycle 36): all blank, busy=0.
//   3. Push 9 chars back-to-back with no start -> 8 accepted. in_ready=0 after the 8th, and the
//      9th is not accepted. The next start pops in order 0..7.
//   4. During DRAIN (2 blanks shifted), push 5 -> the next step shows 5 in digit0, state is
//      SCROLL, and the drain count restarts.
//   5. Pulse start with an empty buffer, and start while busy -> no state change, display
//      unchanged.
//   6. clear with in_valid=1 on a step edge in SCROLL -> display all blank, buffer empty, IDLE,
//      and the character is dropped.

Source files
------------

// File: rtl/hex_msg_scroller_pkg.sv
// Shared types and constants for the hex message scroller display path.
//   CHAR_W        width of one display character code
//   BLANK_DEFAULT code that renders as an empty digit
//   state_e       scroller FSM states
package hex_msg_scroller_pkg;

  localparam int unsigned CHAR_W = 4;
  localparam logic [CHAR_W-1:0] BLANK_DEFAULT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCROLL = 2'd1,
    ST_DRAIN  = 2'd2
  } state_e;

endpackage

// File: rtl/hex_msg_scroller_char_fifo.sv
// Show-ahead synchronous FIFO of character codes.
//   clk, resetn  clock, async active-low reset
//   flush        synchronous empty (wins over push/pop)
//   push, din    enqueue din when not full
//   pop          dequeue head when not empty
//   dout         head entry, valid whenever !empty
//   count        number of stored entries
//   full, empty  status decoded from count
module char_fifo
  import hex_msg_scroller_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [CHAR_W-1:0]        din,
  output logic [CHAR_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CHAR_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  assign w_push = push && !full && !flush;
  assign w_pop  = pop && !empty && !flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/hex_msg_scroller.sv
// Buffers 4-bit character codes and scrolls them right-to-left across
// NUM_DIGITS display positions, one step every TICK_DIV clocks.
//   clk, resetn  clock, async active-low reset
//   in_char      character to enqueue, accepted when in_valid && in_ready
//   in_ready     buffer not full (from registered count)
//   start        pulse: begin scrolling the buffered message
//   clear        synchronous flush of buffer and display
//   busy         high while scrolling or draining
//   disp_chars   digit k at [4k+3:4k], k=0 is the rightmost digit
module hex_msg_scroller
  import hex_msg_scroller_pkg::*;
#(
  parameter int unsigned       NUM_DIGITS = 6,
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter int unsigned       TICK_DIV   = 25_000_000,
  parameter logic [CHAR_W-1:0] BLANK_CHAR = BLANK_DEFAULT
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [CHAR_W-1:0]            in_char,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         start,
  input  logic                         clear,
  output logic                         busy,
  output logic [CHAR_W*NUM_DIGITS-1:0] disp_chars
);

  localparam int unsigned DISP_W = CHAR_W * NUM_DIGITS;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DRN_W  = $clog2(NUM_DIGITS + 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [TICK_W-1:0]  r_tick;
  logic [TICK_W-1:0]  w_tick_nxt;
  logic [DRN_W-1:0]   r_drain;
  logic [DRN_W-1:0]   w_drain_nxt;
  logic [DISP_W-1:0]  r_disp;
  logic               r_busy;
  logic               w_step;
  logic               w_pop;
  logic               w_push;
  logic               w_have_char;
  logic [CHAR_W-1:0]  w_shift_char;
  logic [CHAR_W-1:0]  w_head;
  logic [CNT_W-1:0]   w_count;
  logic               w_full;
  logic               w_empty;

  assign in_ready    = !w_full;
  assign busy        = r_busy;
  assign disp_chars  = r_disp;
  assign w_push      = in_valid && !w_full && !clear;
  assign w_have_char = (w_count != '0);
  // Character entering digit 0 on a step: head if buffered, else blank.
  assign w_shift_char = w_empty ? BLANK_CHAR : w_head;

  char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .flush  (clear),
    .push   (w_push),
    .pop    (w_pop),
    .din    (in_char),
    .dout   (w_head),
    .count  (w_count),
    .full   (w_full),
    .empty  (w_empty)
  );

  // Next-state, tick divider and drain counter.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick;
    w_drain_nxt = r_drain;
    w_step      = 1'b0;
    w_pop       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start && w_have_char) begin
          w_state_nxt = ST_SCROLL;
          w_tick_nxt  = '0;
        end
      end
      ST_SCROLL, ST_DRAIN: begin
        if (r_tick == TICK_W'(TICK_DIV - 1)) begin
          w_step     = 1'b1;
          w_tick_nxt = '0;
          if (w_have_char) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_SCROLL;
            w_drain_nxt = '0;
          end else if (r_state == ST_SCROLL) begin
            w_drain_nxt = DRN_W'(1);
            w_state_nxt = (NUM_DIGITS == 1) ? ST_IDLE : ST_DRAIN;
          end else begin
            w_drain_nxt = r_drain + DRN_W'(1);
            if (r_drain == DRN_W'(NUM_DIGITS - 1)) w_state_nxt = ST_IDLE;
          end
        end else begin
          w_tick_nxt = r_tick + TICK_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // clear overrides everything else in its cycle.
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_tick_nxt  = '0;
      w_drain_nxt = '0;
      w_step      = 1'b0;
      w_pop       = 1'b0;
    end
  end

  // State, counters, busy flag and display shift register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_tick  <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_disp  <= {NUM_DIGITS{BLANK_CHAR}};
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_drain <= w_drain_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (clear) begin
        r_disp <= {NUM_DIGITS{BLANK_CHAR}};
      end else if (w_step) begin
        r_disp <= {r_disp[DISP_W-CHAR_W-1:0], w_shift_char};
      end
    end
  end

endmodule

// File: tb/tb_hex_msg_scroller.sv
// Directed bench for hex_msg_scroller with a 4-cycle scroll tick.
module tb_hex_msg_scroller;

  localparam int unsigned ND = 6;
  localparam int unsigned FD = 8;
  localparam int unsigned TD = 4;

  logic          clk      = 1'b0;
  logic          resetn   = 1'b1;
  logic [3:0]    in_char  = 4'h0;
  logic          in_valid = 1'b0;
  logic          start    = 1'b0;
  logic          clear    = 1'b0;
  logic          in_ready;
  logic          busy;
  logic [4*ND-1:0] disp_chars;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hex_msg_scroller #(
    .NUM_DIGITS (ND),
    .FIFO_DEPTH (FD),
    .TICK_DIV   (TD),
    .BLANK_CHAR (4'hF)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_char    (in_char),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .start      (start),
    .clear      (clear),
    .busy       (busy),
    .disp_chars (disp_chars)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic push_char(input logic [3:0] c);
    in_char  = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    #2 resetn = 1'b0;
    #1;
    check("rst_disp", 32'(disp_chars), 32'h00FFFFFF);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("rst_ready", 32'(in_ready), 32'd1);

    // Three-character message then full drain
    push_char(4'h1);
    push_char(4'h2);
    push_char(4'h3);
    pulse_start();
    check("s2_busy_start", 32'(busy), 32'd1);
    cycles(3);
    check("s2_pre_step", 32'(disp_chars), 32'h00FFFFFF);
    cycles(1);
    check("s2_step1", 32'(disp_chars), 32'h00FFFFF1);
    cycles(4);
    check("s2_step2", 32'(disp_chars), 32'h00FFFF12);
    cycles(4);
    check("s2_step3", 32'(disp_chars), 32'h00FFF123);
    cycles(4);
    check("s2_step4", 32'(disp_chars), 32'h00FF123F);
    check("s2_busy_drain", 32'(busy), 32'd1);
    cycles(16);
    check("s2_step8", 32'(disp_chars), 32'h003FFFFF);
    check("s2_busy_step8", 32'(busy), 32'd1);
    cycles(4);
    check("s2_done_disp", 32'(disp_chars), 32'h00FFFFFF);
    check("s2_done_busy", 32'(busy), 32'd0);

    // Fill the buffer; the ninth character must be refused
    for (int i = 0; i < 9; i++) begin
      in_char  = 4'(i);
      in_valid = 1'b1;
      tick();
      check($sformatf("s3_ready_%0d", i), 32'(in_ready), (i < 7) ? 32'd1 : 32'd0);
    end
    in_valid = 1'b0;
    pulse_start();
    cycles(4);
    check("s3_step1", 32'(disp_chars), 32'h00FFFFF0);
    check("s3_ready_after_pop", 32'(in_ready), 32'd1);
    cycles(20);
    check("s3_step6", 32'(disp_chars), 32'h00012345);
    cycles(8);
    check("s3_step8", 32'(disp_chars), 32'h00234567);
    cycles(4);
    check("s3_step9_no_ninth", 32'(disp_chars), 32'h0034567F);

    // Refill during drain
    cycles(4);
    check("s4_drain2", 32'(disp_chars), 32'h004567FF);
    push_char(4'h5);
    cycles(3);
    check("s4_refill", 32'(disp_chars), 32'h00567FF5);
    check("s4_busy", 32'(busy), 32'd1);
    cycles(4);
    check("s4_blank1", 32'(disp_chars), 32'h0067FF5F);
    cycles(16);
    check("s4_blank5", 32'(disp_chars), 32'h005FFFFF);
    check("s4_busy_blank5", 32'(busy), 32'd1);
    cycles(4);
    check("s4_done_disp", 32'(disp_chars), 32'h00FFFFFF);
    check("s4_done_busy", 32'(busy), 32'd0);

    // start ignored when empty or busy
    pulse_start();
    check("s5_empty_busy", 32'(busy), 32'd0);
    cycles(4);
    check("s5_empty_disp", 32'(disp_chars), 32'h00FFFFFF);
    push_char(4'hA);
    push_char(4'hB);
    pulse_start();
    cycles(1);
    pulse_start();
    cycles(1);
    check("s5_busy_start_pre", 32'(disp_chars), 32'h00FFFFFF);
    cycles(1);
    check("s5_busy_start_step", 32'(disp_chars), 32'h00FFFFFA);

    // clear with a push on a step edge
    cycles(3);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_char  = 4'hC;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("s6_disp", 32'(disp_chars), 32'h00FFFFFF);
    check("s6_busy", 32'(busy), 32'd0);
    check("s6_ready", 32'(in_ready), 32'd1);
    pulse_start();
    check("s6_start_empty", 32'(busy), 32'd0);
    cycles(4);
    check("s6_disp_hold", 32'(disp_chars), 32'h00FFFFFF);

    // Asynchronous reset mid-scroll
    push_char(4'h7);
    pulse_start();
    cycles(4);
    check("s1_pre_rst", 32'(disp_chars), 32'h00FFFFF7);
    #2 resetn = 1'b0;
    #1;
    check("s1_rst_disp", 32'(disp_chars), 32'h00FFFFFF);
    check("s1_rst_busy", 32'(busy), 32'd0);
    check("s1_rst_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    push_char(4'h8);
    pulse_start();
    cycles(3);
    check("s1_post_pre", 32'(disp_chars), 32'h00FFFFFF);
    cycles(1);
    check("s1_post_step", 32'(disp_chars), 32'h00FFFFF8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
